// File: rtl/uart_alu_interface.sv
// uart_alu_interface
// Collects operand A, operand B and an opcode byte from the UART receiver,
// evaluates the ALU operation and hands the result byte to the UART
// transmitter through a start/done handshake.
module uart_alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // Supported opcodes; the upper bits of the opcode byte are ignored.
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'h27);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'h02);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'h03);

  // Shift amounts at or beyond the word width shift every bit out.
  localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

  state_t             state;
  state_t             next_state;
  logic [NB_DATA-1:0] reg_a;
  logic [NB_DATA-1:0] reg_b;
  logic [NB_OP-1:0]   reg_op;
  logic [NB_DATA-1:0] alu_result;
  logic               alu_valid;
  logic               rx_dropped;

  // A received byte is discarded whenever the block is not collecting operands.
  assign rx_dropped = i_rx_done &&
                      ((state == COMPUTE) || (state == SEND) || (state == WAIT_TX));

  // State register; reset abandons any partially collected transaction.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the combinational start pulse and busy flag.
  always_comb begin
    next_state = state;
    o_tx_start = 1'b0;
    o_busy     = 1'b1;
    case (state)
      WAIT_A: begin
        o_busy = 1'b0;
        if (i_rx_done) next_state = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done) next_state = WAIT_OP;
      end
      WAIT_OP: begin
        if (i_rx_done) next_state = COMPUTE;
      end
      COMPUTE: begin
        next_state = SEND;
      end
      SEND: begin
        o_tx_start = 1'b1;
        next_state = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) next_state = WAIT_A;
      end
      default: begin
        next_state = WAIT_A;
      end
    endcase
  end

  // ALU evaluation of the captured operands; unsupported codes yield zero.
  always_comb begin
    alu_result = '0;
    alu_valid  = 1'b1;
    case (reg_op)
      OP_ADD: alu_result = reg_a + reg_b;
      OP_SUB: alu_result = reg_a - reg_b;
      OP_AND: alu_result = reg_a & reg_b;
      OP_OR:  alu_result = reg_a | reg_b;
      OP_XOR: alu_result = reg_a ^ reg_b;
      OP_NOR: alu_result = ~(reg_a | reg_b);
      OP_SRL: begin
        if (reg_b >= SHIFT_LIMIT) alu_result = '0;
        else                      alu_result = reg_a >> reg_b;
      end
      OP_SRA: begin
        if (reg_b >= SHIFT_LIMIT) alu_result = {NB_DATA{reg_a[NB_DATA-1]}};
        else                      alu_result = $unsigned($signed(reg_a) >>> reg_b);
      end
      default: begin
        alu_result = '0;
        alu_valid  = 1'b0;
      end
    endcase
  end

  // Operand capture, result register, sticky opcode error and overrun pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      reg_a      <= '0;
      reg_b      <= '0;
      reg_op     <= '0;
      o_tx_data  <= '0;
      o_op_error <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_overrun <= rx_dropped;
      case (state)
        WAIT_A: begin
          if (i_rx_done) begin
            reg_a      <= i_rx_data;
            o_op_error <= 1'b0;
          end
        end
        WAIT_B: begin
          if (i_rx_done) reg_b <= i_rx_data;
        end
        WAIT_OP: begin
          if (i_rx_done) reg_op <= i_rx_data[NB_OP-1:0];
        end
        COMPUTE: begin
          o_tx_data <= alu_result;
          if (!alu_valid) o_op_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed testbench for uart_alu_interface with hand-computed results.
module tb_uart_alu_interface;

  logic       clk;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       op_error;
  logic       overrun;

  int checks;
  int errors;

  uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_rx_done  (rx_done),
    .i_rx_data  (rx_data),
    .i_tx_done  (tx_done),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .o_busy     (busy),
    .o_op_error (op_error),
    .o_overrun  (overrun)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One received byte followed by an idle cycle.
  task automatic sendByte(input logic [7:0] data);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = data;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Three back-to-back received bytes; returns in the COMPUTE cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] op);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = a;
    @(negedge clk);
    rx_data = b;
    @(negedge clk);
    rx_data = op;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Starting in COMPUTE: checks the start pulse, result and error flag.
  // Optionally pulses tx_done during SEND, which must be ignored.
  task automatic expectResult(input string tag, input logic [7:0] exp_data,
                              input logic exp_err, input logic done_in_send);
    checkOutput({tag, " start_compute"}, 32'(tx_start), 32'd0);
    checkOutput({tag, " busy_compute"}, 32'(busy), 32'd1);
    @(negedge clk);
    if (done_in_send) tx_done = 1'b1;
    checkOutput({tag, " start_send"}, 32'(tx_start), 32'd1);
    checkOutput({tag, " data"}, 32'(tx_data), 32'(exp_data));
    checkOutput({tag, " op_error"}, 32'(op_error), 32'(exp_err));
    @(negedge clk);
    tx_done = 1'b0;
    checkOutput({tag, " start_wait"}, 32'(tx_start), 32'd0);
    checkOutput({tag, " busy_wait"}, 32'(busy), 32'd1);
  endtask

  // Completes the transmit handshake and checks the return to idle.
  task automatic finishTx(input string tag, input logic [7:0] exp_data);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checkOutput({tag, " busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " data_held"}, 32'(tx_data), 32'(exp_data));
  endtask

  // Directed sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset start", 32'(tx_start), 32'd0);
    checkOutput("reset data", 32'(tx_data), 32'd0);
    checkOutput("reset op_error", 32'(op_error), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    applyStimulus(8'h05, 8'h03, 8'h20);
    expectResult("add", 8'h08, 1'b0, 1'b0);
    finishTx("add", 8'h08);

    applyStimulus(8'h03, 8'h05, 8'h22);
    expectResult("sub", 8'hFE, 1'b0, 1'b0);
    finishTx("sub", 8'hFE);

    applyStimulus(8'hF0, 8'h3C, 8'h27);
    expectResult("nor", 8'h03, 1'b0, 1'b0);
    finishTx("nor", 8'h03);

    applyStimulus(8'hF0, 8'h3C, 8'h24);
    expectResult("and", 8'h30, 1'b0, 1'b0);
    finishTx("and", 8'h30);

    applyStimulus(8'hF0, 8'h3C, 8'hE6);
    expectResult("xor_upper_bits", 8'hCC, 1'b0, 1'b0);
    finishTx("xor_upper_bits", 8'hCC);

    applyStimulus(8'h80, 8'h02, 8'h03);
    expectResult("sra", 8'hE0, 1'b0, 1'b0);
    finishTx("sra", 8'hE0);

    applyStimulus(8'h80, 8'h09, 8'h02);
    expectResult("srl_big", 8'h00, 1'b0, 1'b0);
    finishTx("srl_big", 8'h00);

    applyStimulus(8'h80, 8'h09, 8'h03);
    expectResult("sra_big", 8'hFF, 1'b0, 1'b0);
    finishTx("sra_big", 8'hFF);

    // Unsupported opcode: sticky error until the next operand A arrives.
    applyStimulus(8'h12, 8'h34, 8'h3F);
    expectResult("bad_op", 8'h00, 1'b1, 1'b0);
    finishTx("bad_op", 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("bad_op error_held", 32'(op_error), 32'd1);
    sendByte(8'h0A);
    checkOutput("bad_op error_cleared", 32'(op_error), 32'd0);
    sendByte(8'h05);
    sendByte(8'h25);
    expectResult("or", 8'h0F, 1'b0, 1'b0);

    // Byte received while waiting on the transmitter is dropped.
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = 8'hAA;
    @(negedge clk);
    rx_done = 1'b0;
    checkOutput("overrun pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    checkOutput("overrun single", 32'(overrun), 32'd0);
    checkOutput("overrun still_busy", 32'(busy), 32'd1);
    finishTx("or", 8'h0F);
    applyStimulus(8'h01, 8'h01, 8'h20);
    expectResult("after_overrun", 8'h02, 1'b0, 1'b0);

    // Simultaneous rx and tx done in WAIT_TX: completes and drops the byte.
    @(negedge clk);
    rx_done = 1'b1;
    tx_done = 1'b1;
    rx_data = 8'h55;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    checkOutput("both_done busy", 32'(busy), 32'd0);
    checkOutput("both_done overrun", 32'(overrun), 32'd1);

    // tx_done coinciding with the start pulse is ignored.
    applyStimulus(8'h10, 8'h20, 8'h20);
    expectResult("done_in_send", 8'h30, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("done_in_send still_busy", 32'(busy), 32'd1);
    finishTx("done_in_send", 8'h30);

    // Reset mid-transaction discards collected operands.
    sendByte(8'h11);
    sendByte(8'h22);
    checkOutput("mid busy_before_reset", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h20;
    @(negedge clk);
    reset = 1'b0;
    rx_done = 1'b0;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset start", 32'(tx_start), 32'd0);
    checkOutput("mid reset data", 32'(tx_data), 32'd0);
    @(negedge clk);
    checkOutput("mid after_reset start", 32'(tx_start), 32'd0);
    @(negedge clk);
    checkOutput("mid after_reset start2", 32'(tx_start), 32'd0);
    applyStimulus(8'h07, 8'h01, 8'h22);
    expectResult("after_reset", 8'h06, 1'b0, 1'b0);
    finishTx("after_reset", 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
